// File: rtl/handshake_responder_if.sv
// Bundle of the ring-side req/ack lines and the software-visible service status of handshake_responder.
// Four-phase semantics: req rises, ack answers high, req falls, ack falls; each side holds its level until it sees the other side's level.
interface handshake_responder_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] req_i;
  logic [N_CH-1:0] ack_o;
  logic [N_CH-1:0] grant_o;
  logic            svc_done_o;
  logic [CH_W-1:0] svc_ch_o;
  logic [15:0]     token_cnt_o;
  logic            err_o;

  modport slave (
    input  req_i,
    output ack_o, grant_o, svc_done_o, svc_ch_o, token_cnt_o, err_o
  );

  modport master (
    output req_i,
    input  ack_o, grant_o, svc_done_o, svc_ch_o, token_cnt_o, err_o
  );
endinterface

// File: rtl/handshake_responder.sv
// Clocked four-phase req/ack responder: synchronises N_CH requests, serves them round-robin, counts handshakes.
// Optional release watchdog is compiled in with HS_RESP_TIMEOUT_EN.
module handshake_responder #(
  parameter int N_CH           = 4,
  parameter int SERVICE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  handshake_responder_if.slave bus,
  output logic [1:0]           state_o
);
  localparam int CH_W = $clog2(N_CH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    RELEASE = 2'd2
  } state_t;

  if (N_CH < 2 || N_CH > 8 || SERVICE_CYCLES < 1 || SERVICE_CYCLES > 255 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("handshake_responder: parameter out of legal range");
  end

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [CH_W-1:0] svc_ch_q, svc_ch_d;
  logic [N_CH-1:0] ack_q, ack_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic            done_q, done_d;
  logic [15:0]     token_q, token_d;
  logic [N_CH-1:0] meta_q, meta_d;
  logic [N_CH-1:0] sync_q, sync_d;

  logic [N_CH-1:0] pending;
  logic [CH_W-1:0] pick;
  logic            found;

`ifdef HS_RESP_TIMEOUT_EN
  logic [15:0]     wd_q, wd_d;
  logic [N_CH-1:0] stuck_q, stuck_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    meta_d   = bus.req_i;
    sync_d   = meta_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    svc_ch_d = svc_ch_q;
    ack_d    = ack_q;
    grant_d  = grant_q;
    done_d   = 1'b0;
    token_d  = token_q;
`ifdef HS_RESP_TIMEOUT_EN
    wd_d     = wd_q;
    err_d    = err_q;
    // A timed-out channel stays blocked until its request is seen low again.
    stuck_d  = stuck_q & sync_q;
    pending  = sync_q & ~ack_q & ~stuck_q;
`else
    pending  = sync_q & ~ack_q;
`endif

    // Search starts one past the last served channel, giving round-robin order.
    found = 1'b0;
    pick  = svc_ch_q;
    for (int i = 1; i <= N_CH; i++) begin
      int idx;
      idx = (int'(svc_ch_q) + i) % N_CH;
      if (!found && pending[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          svc_ch_d      = pick;
          cnt_d         = 8'(SERVICE_CYCLES - 1);
          state_d       = SERVICE;
        end
      end
      SERVICE: begin
        if (cnt_q == 8'd0) begin
          ack_d[svc_ch_q] = 1'b1;
          state_d         = RELEASE;
`ifdef HS_RESP_TIMEOUT_EN
          wd_d            = 16'd0;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RELEASE: begin
        if (!sync_q[svc_ch_q]) begin
          ack_d   = '0;
          grant_d = '0;
          done_d  = 1'b1;
          token_d = token_q + 16'd1;
          state_d = IDLE;
        end
`ifdef HS_RESP_TIMEOUT_EN
        else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
          err_d             = 1'b1;
          ack_d             = '0;
          grant_d           = '0;
          stuck_d[svc_ch_q] = 1'b1;
          state_d           = IDLE;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      svc_ch_q <= CH_W'(N_CH - 1);
      ack_q    <= '0;
      grant_q  <= '0;
      done_q   <= 1'b0;
      token_q  <= '0;
      meta_q   <= '0;
      sync_q   <= '0;
`ifdef HS_RESP_TIMEOUT_EN
      wd_q     <= '0;
      stuck_q  <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      svc_ch_q <= svc_ch_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      token_q  <= token_d;
      meta_q   <= meta_d;
      sync_q   <= sync_d;
`ifdef HS_RESP_TIMEOUT_EN
      wd_q     <= wd_d;
      stuck_q  <= stuck_d;
      err_q    <= err_d;
`endif
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.grant_o     = grant_q;
  assign bus.svc_done_o  = done_q;
  assign bus.svc_ch_o    = svc_ch_q;
  assign bus.token_cnt_o = token_q;
  assign state_o         = state_q;
`ifdef HS_RESP_TIMEOUT_EN
  assign bus.err_o       = err_q;
`else
  assign bus.err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_handshake_responder.sv
// Self-checking bench for handshake_responder: exact-edge timing, round-robin order, wrap, async reset, watchdog.
// The reference model predicts grant order and token count from the round-robin and counting rules.
module tb_handshake_responder;
  localparam int N_CH = 4;
  localparam int SC   = 2;
  localparam int TO   = 8;

  logic       clk;
  logic       reset_n;
  logic [1:0] state_o;

  handshake_responder_if #(.N_CH(N_CH)) bus ();

  handshake_responder #(
    .N_CH(N_CH), .SERVICE_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_tokens;
  int          model_last;
  logic [3:0]  exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    bus.req_i  = '0;
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    model_last   = N_CH - 1;
    model_tokens = 16'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output int ch, output bit ok);
    ok = 1'b0;
    ch = -1;
    for (int t = 0; t < 40 && !ok; t++) begin
      tick();
      if (bus.grant_o != '0) begin
        ok = 1'b1;
        for (int i = 0; i < N_CH; i++) if (bus.grant_o[i]) ch = i;
      end
    end
  endtask

  // Serves the expected channel through one full handshake, checking each phase.
  task automatic serve_one(input int exp, input int hold, input bit rearm);
    int         ch;
    bit         ok;
    int         n;
    logic [3:0] onehot;
    onehot      = '0;
    onehot[exp] = 1'b1;

    wait_grant(ch, ok);
    n_checks++;
    if (!ok || bus.grant_o !== onehot || bus.svc_ch_o !== 2'(exp)) begin
      n_fail++;
      $display("FAIL grant: got grant=%b svc_ch=%0d ok=%0d, want grant=%b", bus.grant_o, bus.svc_ch_o, ok, onehot);
    end

    n  = 0;
    ok = 1'b0;
    while (n < SC + 10 && !ok) begin
      tick();
      n++;
      if (bus.ack_o != '0) ok = 1'b1;
    end
    n_checks++;
    if (!ok || n != SC || bus.ack_o !== onehot) begin
      n_fail++;
      $display("FAIL ack_latency: got ack=%b after %0d cycles, want ack=%b after %0d", bus.ack_o, n, onehot, SC);
    end

    for (int h = 0; h < hold; h++) begin
      tick();
      n_checks++;
      if (bus.ack_o !== onehot || bus.grant_o !== onehot) begin
        n_fail++;
        $display("FAIL ack_hold: got ack=%b grant=%b, want %b", bus.ack_o, bus.grant_o, onehot);
      end
    end

    @(negedge clk);
    bus.req_i[exp] = 1'b0;
    n  = 0;
    ok = 1'b0;
    while (n < 10 && !ok) begin
      tick();
      n++;
      if (bus.svc_done_o) ok = 1'b1;
    end
    model_tokens = model_tokens + 16'd1;
    model_last   = exp;
    n_checks++;
    if (!ok || n != 3 || bus.ack_o !== 4'b0000 || bus.grant_o !== 4'b0000 || bus.token_cnt_o !== model_tokens) begin
      n_fail++;
      $display("FAIL release: done=%0d after %0d, ack=%b grant=%b tokens=%h, want done after 3, ack=0 grant=0 tokens=%h",
               ok, n, bus.ack_o, bus.grant_o, bus.token_cnt_o, model_tokens);
    end
    if (rearm) begin
      @(negedge clk);
      bus.req_i[exp] = 1'b1;
    end
  endtask

  // Raises all channels in mask together; model predicts service order by rotating from the last served channel.
  task automatic run_round(input logic [3:0] mask, input int hold_max);
    int c;
    c = model_last;
    exp_q.delete();
    for (int k = 0; k < N_CH; k++) begin
      c = (c + 1) % N_CH;
      if (mask[c]) exp_q.push_back(4'(c));
    end
    @(negedge clk);
    bus.req_i = bus.req_i | mask;
    while (exp_q.size() > 0) begin
      serve_one(int'(exp_q.pop_front()), int'($urandom_range(0, hold_max)), 1'b0);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tick();
    n_checks++;
    if (bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", bus.ack_o); end
    n_checks++;
    if (bus.grant_o !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus.grant_o); end
    n_checks++;
    if (bus.svc_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.svc_done_o); end
    n_checks++;
    if (bus.token_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL reset_tokens: got %h want 0000", bus.token_cnt_o); end
    n_checks++;
    if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    n_checks++;
    if (bus.svc_ch_o !== 2'(N_CH - 1)) begin n_fail++; $display("FAIL reset_svc_ch: got %0d want %0d", bus.svc_ch_o, N_CH - 1); end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    bus.req_i = 4'b0001;
    tick();  // edge 0
    tick();  // edge 1
    n_checks++;
    if (bus.grant_o !== 4'b0000) begin n_fail++; $display("FAIL single_e1_grant: got %b want 0000", bus.grant_o); end
    tick();  // edge 2
    n_checks++;
    if (bus.grant_o !== 4'b0001 || bus.svc_ch_o !== 2'd0) begin
      n_fail++; $display("FAIL single_e2_grant: got %b ch=%0d want 0001 ch=0", bus.grant_o, bus.svc_ch_o);
    end
    tick();  // edge 3
    n_checks++;
    if (bus.ack_o !== 4'b0000) begin n_fail++; $display("FAIL single_e3_ack: got %b want 0000", bus.ack_o); end
    tick();  // edge 4
    n_checks++;
    if (bus.ack_o !== 4'b0001) begin n_fail++; $display("FAIL single_e4_ack: got %b want 0001", bus.ack_o); end
    tick();  // edge 5
    @(negedge clk);
    bus.req_i = 4'b0000;
    tick();  // edge 6
    tick();  // edge 7
    n_checks++;
    if (bus.ack_o !== 4'b0001 || bus.svc_done_o !== 1'b0) begin
      n_fail++; $display("FAIL single_e7: got ack=%b done=%b want ack=0001 done=0", bus.ack_o, bus.svc_done_o);
    end
    tick();  // edge 8
    n_checks++;
    if (bus.ack_o !== 4'b0000 || bus.svc_done_o !== 1'b1 || bus.token_cnt_o !== 16'd1 || bus.grant_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_e8: got ack=%b done=%b tokens=%h grant=%b want 0000 1 0001 0000",
               bus.ack_o, bus.svc_done_o, bus.token_cnt_o, bus.grant_o);
    end
    tick();  // edge 9
    n_checks++;
    if (bus.svc_done_o !== 1'b0) begin n_fail++; $display("FAIL single_e9_done: got %b want 0", bus.svc_done_o); end
    model_last   = 0;
    model_tokens = 16'd1;
  endtask

  task automatic test_all_four();
    do_reset();
    run_round(4'b1111, 2);
    n_checks++;
    if (bus.token_cnt_o !== 16'd4) begin n_fail++; $display("FAIL all_four_tokens: got %0d want 4", bus.token_cnt_o); end
  endtask

  task automatic test_fairness();
    int exp;
    do_reset();
    @(negedge clk);
    bus.req_i = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      exp = model_last;
      do exp = (exp + 1) % N_CH; while (exp != 0 && exp != 2);
      serve_one(exp, 1, k < 2);
    end
    n_checks++;
    if (bus.token_cnt_o !== 16'd4) begin n_fail++; $display("FAIL fairness_tokens: got %0d want 4", bus.token_cnt_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut.token_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.token_q;
    model_tokens = 16'hFFFF;
    run_round(4'b0100, 0);
    n_checks++;
    if (bus.token_cnt_o !== 16'h0000) begin n_fail++; $display("FAIL wrap_tokens: got %h want 0000", bus.token_cnt_o); end
  endtask

  task automatic test_reset_mid();
    int ch;
    bit ok;
    int n;
    do_reset();
    run_round(4'b0001, 0);
    @(negedge clk);
    bus.req_i = 4'b0010;
    wait_grant(ch, ok);
    n_checks++;
    if (!ok || ch != 1) begin n_fail++; $display("FAIL mid_service_grant: got ch=%0d want 1", ch); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ack_o !== 4'b0000 || bus.grant_o !== 4'b0000 || bus.svc_done_o !== 1'b0 ||
        bus.token_cnt_o !== 16'd0 || bus.err_o !== 1'b0 || bus.svc_ch_o !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_service_reset: ack=%b grant=%b done=%b tokens=%h err=%b ch=%0d want all 0, ch=3",
               bus.ack_o, bus.grant_o, bus.svc_done_o, bus.token_cnt_o, bus.err_o, bus.svc_ch_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      tick();
      n++;
      if (bus.ack_o != '0) ok = 1'b1;
    end
    n_checks++;
    if (!ok || bus.ack_o !== 4'b0010) begin n_fail++; $display("FAIL mid_release_ack: got %b want 0010", bus.ack_o); end
    #2 reset_n = 1'b0;
    bus.req_i = 4'b0000;
    #1;
    n_checks++;
    if (bus.ack_o !== 4'b0000 || bus.grant_o !== 4'b0000 || bus.token_cnt_o !== 16'd0 || bus.svc_ch_o !== 2'd3) begin
      n_fail++;
      $display("FAIL mid_release_reset: ack=%b grant=%b tokens=%h ch=%0d want 0 0 0 3",
               bus.ack_o, bus.grant_o, bus.token_cnt_o, bus.svc_ch_o);
    end
    @(negedge clk);
    reset_n      = 1'b1;
    model_last   = N_CH - 1;
    model_tokens = 16'd0;
    run_round(4'b0011, 1);
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 10; r++) begin
      run_round(4'($urandom_range(1, 15)), 3);
    end
    n_checks++;
    if (bus.token_cnt_o !== model_tokens) begin
      n_fail++; $display("FAIL random_tokens: got %0d want %0d", bus.token_cnt_o, model_tokens);
    end
  endtask

`ifdef HS_RESP_TIMEOUT_EN
  task automatic test_timeout();
    int ch;
    bit ok;
    int n;
    bit gone;
    bit saw_done;
    do_reset();
    @(negedge clk);
    bus.req_i = 4'b0010;
    wait_grant(ch, ok);
    n  = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      tick();
      n++;
      if (bus.ack_o != '0) ok = 1'b1;
    end
    n_checks++;
    if (!ok || ch != 1) begin n_fail++; $display("FAIL timeout_setup: ch=%0d ack=%b want ch=1 ack=0010", ch, bus.ack_o); end
    n        = 0;
    gone     = 1'b0;
    saw_done = 1'b0;
    while (n < TO + 6 && !gone) begin
      tick();
      n++;
      if (bus.svc_done_o) saw_done = 1'b1;
      if (bus.ack_o == '0) gone = 1'b1;
    end
    n_checks++;
    if (!gone || n != TO || bus.err_o !== 1'b1 || saw_done || bus.token_cnt_o !== model_tokens || bus.grant_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_fire: ack_gone=%0d after %0d err=%b done_seen=%0d tokens=%0d want gone after %0d err=1 no done tokens=%0d",
               gone, n, bus.err_o, saw_done, bus.token_cnt_o, TO, model_tokens);
    end
    model_last = 1;
    @(negedge clk);
    bus.req_i[3] = 1'b1;
    serve_one(3, 0, 1'b0);
    @(negedge clk);
    bus.req_i[1] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    bus.req_i[1] = 1'b1;
    serve_one(1, 0, 1'b0);
    n_checks++;
    if (bus.err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got err=%b want 1", bus.err_o); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset_n   = 1'b0;
    bus.req_i = '0;
    model_last   = N_CH - 1;
    model_tokens = 16'd0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef HS_RESP_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
